alu_multibyte_add_seq: RTL and testbench

- Sequencing stage wrapped around the team's existing 8-bit ripple-carry adder.
- Accepts two NBYTES-wide operands and an add/sub select through a valid/ready handshake.
- Feeds the adder one byte per cycle, LSB first, chaining the carry through a register.
- Collects the returned sum bytes and presents the full-width result plus carry, overflow and zero flags through a valid/ready handshake.

---
 rtl/alu_multibyte_add_seq.sv | 118 +++++++++++
 tb/tb_alu_multibyte_add_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_add_seq.sv
// Byte-serial sequencer around an external 8-bit ripple-carry adder.
// Operands arrive through a valid/ready handshake. The result and flags leave through a second one.
module alu_multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [8*NBYTES-1:0]   iA,
    input  logic [8*NBYTES-1:0]   iB,
    input  logic                  iSub,
    output logic [7:0]            oAddA,
    output logic [7:0]            oAddB,
    output logic                  oAddC,
    input  logic [7:0]            iAddSum,
    input  logic                  iAddCarry,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [8*NBYTES-1:0]   oResult,
    output logic                  oCarry,
    output logic                  oOverflow,
    output logic                  oZero
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic            zero_acc;
    logic [IW-1:0]   idx;
    logic            last;
    logic            accept;

    assign last   = (idx == IW'(NBYTES - 1));
    assign accept = (state == IDLE) && iValid;

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (iValid) state_next = RUN;
            RUN:  if (last) state_next = DONE;
            DONE: if (iReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and adder drive; the adder answers within the same cycle
    always_comb begin
        oReady = 1'b0;
        oValid = 1'b0;
        oAddA  = 8'h00;
        oAddB  = 8'h00;
        oAddC  = 1'b0;
        case (state)
            IDLE: oReady = 1'b1;
            RUN: begin
                oAddA = a_reg[8*idx +: 8];
                oAddB = b_reg[8*idx +: 8];
                oAddC = carry_reg;
            end
            DONE: oValid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, byte collection and final flags
    always_ff @(posedge iClk) begin
        if (iRst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b0;
            idx       <= '0;
            oResult   <= '0;
            oCarry    <= 1'b0;
            oOverflow <= 1'b0;
            oZero     <= 1'b0;
        end else if (accept) begin
            a_reg     <= iA;
            b_reg     <= iSub ? ~iB : iB;
            carry_reg <= iSub;
            zero_acc  <= 1'b1;
            idx       <= '0;
        end else if (state == RUN) begin
            oResult[8*idx +: 8] <= iAddSum;
            carry_reg           <= iAddCarry;
            zero_acc            <= zero_acc && (iAddSum == 8'h00);
            idx                 <= idx + IW'(1);
            if (last) begin
                oCarry    <= iAddCarry;
                oOverflow <= (a_reg[W-1] == b_reg[W-1]) && (iAddSum[7] != a_reg[W-1]);
                oZero     <= zero_acc && (iAddSum == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_alu_multibyte_add_seq.sv
// Directed bench for alu_multibyte_add_seq with NBYTES=4.
// A behavioural 8-bit adder closes the loop around the DUT.
module tb_alu_multibyte_add_seq;

    localparam int unsigned NB = 4;

    logic             iClk = 1'b0;
    logic             iRst = 1'b0;
    logic             iValid = 1'b0;
    logic             oReady;
    logic [8*NB-1:0]  iA = '0;
    logic [8*NB-1:0]  iB = '0;
    logic             iSub = 1'b0;
    logic [7:0]       oAddA;
    logic [7:0]       oAddB;
    logic             oAddC;
    logic [7:0]       iAddSum;
    logic             iAddCarry;
    logic             oValid;
    logic             iReady = 1'b0;
    logic [8*NB-1:0]  oResult;
    logic             oCarry;
    logic             oOverflow;
    logic             oZero;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    assign {iAddCarry, iAddSum} = 9'(oAddA) + 9'(oAddB) + 9'(oAddC);

    alu_multibyte_add_seq #(.NBYTES(NB)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .iSub(iSub),
        .oAddA(oAddA), .oAddB(oAddB), .oAddC(oAddC),
        .iAddSum(iAddSum), .iAddCarry(iAddCarry),
        .oValid(oValid), .iReady(iReady),
        .oResult(oResult), .oCarry(oCarry), .oOverflow(oOverflow), .oZero(oZero)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: oReady=%b oValid=%b, required 1/0", tag, oReady, oValid);
        end
        checks++;
        if (oAddA !== 8'h00 || oAddB !== 8'h00 || oAddC !== 1'b0) begin
            errors++;
            $display("FAIL %s adder drive: %h/%h/%b, required 00/00/0", tag, oAddA, oAddB, oAddC);
        end
    endtask

    // Launch one operation and check the RUN cycles, latency and result
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [7:0] b0, input logic [3:0] cseq,
                          input logic [31:0] res, input logic c, input logic v, input logic z);
        iA = a; iB = b; iSub = sub; iValid = 1'b1; iReady = 1'b0;
        step();
        iValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (oReady !== 1'b0 || oValid !== 1'b0 || oAddC !== cseq[k]) begin
                errors++;
                $display("FAIL %s run%0d: oReady=%b oValid=%b oAddC=%b, required 0/0/%b",
                         tag, k, oReady, oValid, oAddC, cseq[k]);
            end
            if (k == 0) begin
                checks++;
                if (oAddA !== a[7:0] || oAddB !== b0) begin
                    errors++;
                    $display("FAIL %s byte0: oAddA=%h oAddB=%h, required %h/%h",
                             tag, oAddA, oAddB, a[7:0], b0);
                end
            end
            step();
        end
        checks++;
        if (oValid !== 1'b1 || oReady !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: oValid=%b oReady=%b, required 1/0", tag, oValid, oReady);
        end
        checks++;
        if (oResult !== res || oCarry !== c || oOverflow !== v || oZero !== z) begin
            errors++;
            $display("FAIL %s result: %h c%b v%b z%b, required %h c%b v%b z%b",
                     tag, oResult, oCarry, oOverflow, oZero, res, c, v, z);
        end
    endtask

    task automatic take_result(input string tag);
        iReady = 1'b1; iValid = 1'b1;
        step();
        iReady = 1'b0; iValid = 1'b0;
        check_idle_outputs(tag);
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
        check_idle_outputs("reset");
        checks++;
        if (oResult !== 32'h0 || oCarry !== 1'b0 || oOverflow !== 1'b0 || oZero !== 1'b0) begin
            errors++;
            $display("FAIL reset result: %h c%b v%b z%b, required 0", oResult, oCarry, oOverflow, oZero);
        end
    endtask

    task automatic test_add();
        run_op("add_ff_1", 32'h000000FF, 32'h00000001, 1'b0, 8'h01, 4'b0010,
               32'h00000100, 1'b0, 1'b0, 1'b0);
        take_result("add_ff_1");
        run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 8'h01, 4'b1110,
               32'h00000000, 1'b1, 1'b0, 1'b1);
        take_result("add_wrap");
        run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 8'h01, 4'b1110,
               32'h80000000, 1'b0, 1'b1, 1'b0);
        take_result("add_ovf");
    endtask

    task automatic test_sub();
        run_op("sub_5_7", 32'h00000005, 32'h00000007, 1'b1, 8'hF8, 4'b0001,
               32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        take_result("sub_5_7");
        run_op("sub_7_7", 32'h00000007, 32'h00000007, 1'b1, 8'hF8, 4'b1111,
               32'h00000000, 1'b1, 1'b0, 1'b1);
        take_result("sub_7_7");
    endtask

    // Result held under backpressure while new operands are offered
    task automatic test_backpressure();
        run_op("bp", 32'h12345678, 32'h11111111, 1'b0, 8'h11, 4'b0000,
               32'h23456789, 1'b0, 1'b0, 1'b0);
        iA = 32'hDEADBEEF; iB = 32'h01010101; iValid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oResult !== 32'h23456789) begin
                errors++;
                $display("FAIL bp hold%0d: oValid=%b oReady=%b oResult=%h, required 1/0/23456789",
                         k, oValid, oReady, oResult);
            end
        end
        take_result("bp");
        run_op("bp_next", 32'h00000001, 32'h00000001, 1'b0, 8'h01, 4'b0000,
               32'h00000002, 1'b0, 1'b0, 1'b0);
        take_result("bp_next");
    endtask

    task automatic test_reset_mid_run();
        iA = 32'h01020304; iB = 32'h05060708; iSub = 1'b0; iValid = 1'b1;
        step();
        iValid = 1'b0;
        step();
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        check_idle_outputs("rst_run");
        checks++;
        if (oResult !== 32'h0 || oCarry !== 1'b0 || oOverflow !== 1'b0 || oZero !== 1'b0) begin
            errors++;
            $display("FAIL rst_run result: %h c%b v%b z%b, required 0", oResult, oCarry, oOverflow, oZero);
        end
        run_op("after_rst", 32'h00000003, 32'h00000004, 1'b0, 8'h04, 4'b0000,
               32'h00000007, 1'b0, 1'b0, 1'b0);
        take_result("after_rst");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
